// File: rtl/stack_cpu_param.sv
// stack_cpu_param: single-cycle parametrised stack machine, external combinational imem, internal data RAM.
// Define MUL_EN to enable opcode 8 (signed MUL); otherwise opcode 8 is illegal and faults.
module stack_cpu_param #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned OP_W        = 8,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [OP_W-1:0]          imem_addr,
  input  logic [OP_W+3:0]          imem_data,
  input  logic signed [DATA_W-1:0] X,
  output logic signed [DATA_W-1:0] Y,
  output logic                     error,
  output logic                     fault,
  output logic                     halted
);
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned STK_N = 2 ** IDX_W;
  localparam int unsigned MEM_N = 2 ** OP_W;
  localparam logic [OP_W-1:0] IN_ADDR  = OP_W'(MEM_N - 8);
  localparam logic [OP_W-1:0] OUT_ADDR = OP_W'(MEM_N - 1);
  localparam logic [SP_W-1:0] SP_FULL  = SP_W'(STACK_DEPTH);

  typedef enum logic [3:0] {
    OP_PUSHC = 4'h0, OP_PUSH = 4'h1, OP_POP = 4'h2, OP_JUMP = 4'h3,
    OP_JZ    = 4'h4, OP_DUP  = 4'h5, OP_ADD = 4'h6, OP_SUB  = 4'h7,
    OP_MUL   = 4'h8, OP_HALT = 4'hF
  } opcode_e;

  typedef struct packed {
    logic [3:0]      opcode;
    logic [OP_W-1:0] operand;
  } instr_t;

  instr_t            instr;
  logic [OP_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              error_q, error_d, fault_q, fault_d, halted_q, halted_d;

  logic [DATA_W-1:0] stk_q [STK_N];
  logic [DATA_W-1:0] ram_q [MEM_N];
  logic              stk_we, ram_we;
  logic [IDX_W-1:0]  stk_waddr;
  logic [DATA_W-1:0] stk_wdata, ram_wdata;
  logic [OP_W-1:0]   ram_waddr;

  logic [IDX_W-1:0]  top_idx, sec_idx, push_idx;
  logic [DATA_W-1:0] a, b, imm, sum, diff, ld_data;
  logic              full, has1, has2, add_ovf, sub_ovf, bad;

  assign instr    = instr_t'(imem_data);
  assign top_idx  = IDX_W'(sp_q - SP_W'(1));
  assign sec_idx  = IDX_W'(sp_q - SP_W'(2));
  assign push_idx = IDX_W'(sp_q);
  assign b        = stk_q[top_idx];
  assign a        = stk_q[sec_idx];
  assign imm      = DATA_W'($signed(instr.operand));
  assign sum      = a + b;
  assign diff     = a - b;
  assign add_ovf  = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
  assign sub_ovf  = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
  assign full     = (sp_q == SP_FULL);
  assign has1     = (sp_q != '0);
  assign has2     = (sp_q >= SP_W'(2));

`ifdef MUL_EN
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          prod_lo;
  logic                       mul_ovf;
  assign prod    = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
  assign prod_lo = prod[DATA_W-1:0];
  assign mul_ovf = (prod != (2*DATA_W)'($signed(prod_lo)));
`endif

  // Memory-mapped load source: X and Y shadow their RAM addresses.
  always_comb begin
    if (instr.operand == IN_ADDR)       ld_data = X;
    else if (instr.operand == OUT_ADDR) ld_data = y_q;
    else                                ld_data = ram_q[instr.operand];
  end

  always_comb begin
    pc_d      = pc_q;
    sp_d      = sp_q;
    y_d       = y_q;
    error_d   = error_q;
    fault_d   = fault_q;
    halted_d  = halted_q;
    stk_we    = 1'b0;
    stk_waddr = push_idx;
    stk_wdata = imm;
    ram_we    = 1'b0;
    ram_waddr = instr.operand;
    ram_wdata = b;
    bad       = 1'b0;
    if (!halted_q) begin
      pc_d = pc_q + OP_W'(1);
      case (instr.opcode)
        OP_PUSHC: if (full) bad = 1'b1;
                  else begin stk_we = 1'b1; stk_wdata = imm; sp_d = sp_q + SP_W'(1); end
        OP_PUSH:  if (full) bad = 1'b1;
                  else begin stk_we = 1'b1; stk_wdata = ld_data; sp_d = sp_q + SP_W'(1); end
        OP_POP:   if (!has1) bad = 1'b1;
                  else begin
                    sp_d = sp_q - SP_W'(1);
                    if (instr.operand == OUT_ADDR)     y_d = b;
                    else if (instr.operand != IN_ADDR) ram_we = 1'b1;
                  end
        OP_JUMP:  pc_d = instr.operand;
        OP_JZ:    if (!has1) bad = 1'b1;
                  else begin
                    sp_d = sp_q - SP_W'(1);
                    if (b == '0) pc_d = instr.operand;
                  end
        OP_DUP:   if (!has1 || full) bad = 1'b1;
                  else begin stk_we = 1'b1; stk_wdata = b; sp_d = sp_q + SP_W'(1); end
        OP_ADD:   if (!has2) bad = 1'b1;
                  else begin
                    stk_we = 1'b1; stk_waddr = sec_idx; stk_wdata = sum; sp_d = sp_q - SP_W'(1);
                    if (add_ovf) error_d = 1'b1;
                  end
        OP_SUB:   if (!has2) bad = 1'b1;
                  else begin
                    stk_we = 1'b1; stk_waddr = sec_idx; stk_wdata = diff; sp_d = sp_q - SP_W'(1);
                    if (sub_ovf) error_d = 1'b1;
                  end
`ifdef MUL_EN
        OP_MUL:   if (!has2) bad = 1'b1;
                  else begin
                    stk_we = 1'b1; stk_waddr = sec_idx; stk_wdata = prod_lo; sp_d = sp_q - SP_W'(1);
                    if (mul_ovf) error_d = 1'b1;
                  end
`endif
        OP_HALT:  begin halted_d = 1'b1; pc_d = pc_q; end
        default:  bad = 1'b1;
      endcase
      // A faulting instruction leaves all architectural state untouched.
      if (bad) begin
        pc_d     = pc_q;
        sp_d     = sp_q;
        y_d      = y_q;
        stk_we   = 1'b0;
        ram_we   = 1'b0;
        error_d  = 1'b1;
        fault_d  = 1'b1;
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      sp_q     <= '0;
      y_q      <= '0;
      error_q  <= 1'b0;
      fault_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      y_q      <= y_d;
      error_q  <= error_d;
      fault_q  <= fault_d;
      halted_q <= halted_d;
    end
  end

  // Stack and data RAM are not cleared by reset, but reset blocks writes.
  always_ff @(posedge clk) begin
    if (stk_we && !reset) stk_q[stk_waddr] <= stk_wdata;
    if (ram_we && !reset) ram_q[ram_waddr] <= ram_wdata;
  end

  assign imem_addr = pc_q;
  assign Y         = y_q;
  assign error     = error_q;
  assign fault     = fault_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_stack_cpu_param.sv
// Bench for stack_cpu_param: behavioural queue-based model, per-cycle compare, directed and random programs.
module tb_stack_cpu_param;
  localparam int DEPTH = 8;
  localparam int IN_A  = 248;
  localparam int OUT_A = 255;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        imem_addr;
  logic [11:0]       imem_data;
  logic signed [7:0] X;
  logic signed [7:0] Y;
  logic              error, fault, halted;

  logic [11:0] prog [256];
  assign imem_data = prog[imem_addr];

  stack_cpu_param #(.DATA_W(8), .OP_W(8), .STACK_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .X(X), .Y(Y), .error(error), .fault(fault), .halted(halted)
  );

  always #5 clk = ~clk;

  int  m_pc, m_y;
  bit  m_err, m_flt, m_hlt;
  int  m_stk[$];
  int  m_mem [256];
  int  n_pass = 0;
  int  n_total = 0;
  bit  chk_en = 1'b0;
  bit  x_rand = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int wrap8(input int v);
    logic [7:0] t;
    t = v[7:0];
    return int'($signed(t));
  endfunction

  function automatic int rd(input int addr);
    if (addr == IN_A)  return int'(X);
    if (addr == OUT_A) return m_y;
    return m_mem[addr];
  endfunction

  task automatic model_reset();
    m_pc = 0; m_y = 0; m_err = 1'b0; m_flt = 1'b0; m_hlt = 1'b0;
    m_stk.delete();
  endtask

  // One instruction of the reference machine; faults are detected before any mutation.
  task automatic model_step();
    int op, opr, a, b, r, nxt;
    bit flt;
    if (m_hlt) return;
    op  = int'(prog[m_pc][11:8]);
    opr = int'(prog[m_pc][7:0]);
    nxt = (m_pc + 1) % 256;
    flt = 1'b0;
    case (op)
      0: if (m_stk.size() == DEPTH) flt = 1'b1; else m_stk.push_back(wrap8(opr));
      1: if (m_stk.size() == DEPTH) flt = 1'b1; else m_stk.push_back(rd(opr));
      2: if (m_stk.size() < 1) flt = 1'b1;
         else begin
           b = m_stk.pop_back();
           if (opr == OUT_A) m_y = b;
           else if (opr != IN_A) m_mem[opr] = b;
         end
      3: nxt = opr;
      4: if (m_stk.size() < 1) flt = 1'b1;
         else begin b = m_stk.pop_back(); if (b == 0) nxt = opr; end
      5: if (m_stk.size() < 1 || m_stk.size() == DEPTH) flt = 1'b1;
         else m_stk.push_back(m_stk[$]);
      6, 7: if (m_stk.size() < 2) flt = 1'b1;
         else begin
           b = m_stk.pop_back(); a = m_stk.pop_back();
           r = (op == 6) ? a + b : a - b;
           if (r > 127 || r < -128) m_err = 1'b1;
           m_stk.push_back(wrap8(r));
         end
`ifdef MUL_EN
      8: if (m_stk.size() < 2) flt = 1'b1;
         else begin
           b = m_stk.pop_back(); a = m_stk.pop_back();
           r = a * b;
           if (r > 127 || r < -128) m_err = 1'b1;
           m_stk.push_back(wrap8(r));
         end
`endif
      15: begin m_hlt = 1'b1; nxt = m_pc; end
      default: flt = 1'b1;
    endcase
    if (flt) begin m_flt = 1'b1; m_err = 1'b1; m_hlt = 1'b1; end
    else m_pc = nxt;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc",     int'(imem_addr), m_pc);
      chk("Y",      int'(Y),         m_y);
      chk("error",  int'(error),     int'(m_err));
      chk("fault",  int'(fault),     int'(m_flt));
      chk("halted", int'(halted),    int'(m_hlt));
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (x_rand) X = 8'($urandom);
  endtask

  task automatic reset_on();
    @(negedge clk); #2;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic reset_off();
    @(negedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 12'hF00;
  endtask

  task automatic run_until_halt(input int budget, input string name);
    int n = 0;
    while (!halted && n < budget) begin cycle(); n++; end
    chk(name, int'(halted), 1);
  endtask

  task automatic gen_random();
    int r;
    logic [7:0] addrs [6];
    addrs = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hF8, 8'hFF};
    clear_prog();
    for (int i = 0; i < 4; i++) begin
      prog[2*i]   = {4'h0, 8'($urandom)};
      prog[2*i+1] = {4'h2, 8'(8'h10 + i)};
    end
    for (int p = 8; p < 48; p++) begin
      r = $urandom_range(0, 99);
      if      (r < 18) prog[p] = {4'h0, 8'($urandom)};
      else if (r < 28) prog[p] = {4'h1, addrs[$urandom_range(0, 5)]};
      else if (r < 38) prog[p] = {4'h2, addrs[$urandom_range(0, 5)]};
      else if (r < 42) prog[p] = {4'h3, 8'($urandom_range(8, 47))};
      else if (r < 50) prog[p] = {4'h4, 8'($urandom_range(8, 47))};
      else if (r < 58) prog[p] = {4'h5, 8'($urandom)};
      else if (r < 70) prog[p] = 12'h600;
      else if (r < 80) prog[p] = 12'h700;
      else if (r < 88) prog[p] = 12'h800;
      else if (r < 91) prog[p] = 12'hF00;
      else if (r < 95) prog[p] = {4'($urandom_range(9, 14)), 8'h00};
      else             prog[p] = {4'h0, 8'($urandom_range(0, 3))};
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1;
    X = '0;
    model_reset();
    clear_prog();
    #12;
    chk("rst_pc", int'(imem_addr), 0);
    chk("rst_Y", int'(Y), 0);
    chk("rst_flags", int'({error, fault, halted}), 0);
    chk_en = 1'b1;

    // Memory round-trip, arithmetic, then push loop until overflow fault.
    reset_on(); clear_prog();
    prog[0] = 12'h1F8; prog[1] = 12'h017; prog[2] = 12'h600; prog[3] = 12'h2AA;
    prog[4] = 12'h1AA; prog[5] = 12'h1AA; prog[6] = 12'h600; prog[7] = 12'h00C;
    prog[8] = 12'h700; prog[9] = 12'h2FF; prog[10] = 12'h00A; prog[11] = 12'h30A;
    x_rand = 1'b0; X = 8'sd5;
    reset_off();
    repeat (10) cycle();
    chk("t1_Y44", int'(Y), 44);
    chk("t1_err0", int'(error), 0);
    run_until_halt(40, "t1_halt");
    chk("t1_fault", int'(fault), 1);
    chk("t1_err", int'(error), 1);
    chk("t1_pc", int'(imem_addr), 10);
    chk("t1_Yhold", int'(Y), 44);

    // Asynchronous reset in the middle of the loop.
    reset_on(); reset_off();
    repeat (15) cycle();
    #2;
    reset = 1'b1;
    #1;
    chk("t5_pc", int'(imem_addr), 0);
    chk("t5_Y", int'(Y), 0);
    chk("t5_flags", int'({error, fault, halted}), 0);
    model_reset();
    reset_off();
    cycle();
    chk("t5_first_fetch", int'(imem_addr), 1);

    // Signed overflow then HALT.
    reset_on(); clear_prog();
    prog[0] = 12'h07F; prog[1] = 12'h001; prog[2] = 12'h600; prog[3] = 12'h2FF; prog[4] = 12'hF00;
    reset_off();
    run_until_halt(10, "t2_halt");
    chk("t2_Y", int'(Y), -128);
    chk("t2_err", int'(error), 1);
    chk("t2_fault", int'(fault), 0);
    chk("t2_pc", int'(imem_addr), 4);

    // Underflow on the very first instruction.
    reset_on(); clear_prog();
    prog[0] = 12'h600;
    reset_off();
    cycle();
    chk("t3_flags", int'({error, fault, halted}), 7);
    chk("t3_pc", int'(imem_addr), 0);
    chk("t3_Y", int'(Y), 0);

    // JZ taken and not taken; DUP afterwards proves the stack is empty.
    reset_on(); clear_prog();
    prog[0] = 12'h000; prog[1] = 12'h405; prog[5] = 12'h003; prog[6] = 12'h409; prog[7] = 12'h500;
    reset_off();
    repeat (2) cycle();
    chk("t4_taken", int'(imem_addr), 5);
    repeat (2) cycle();
    chk("t4_not_taken", int'(imem_addr), 7);
    cycle();
    chk("t4_empty", int'(fault), 1);
    chk("t4_pc", int'(imem_addr), 7);

    // MUL: result with MUL_EN, illegal-opcode fault without.
    reset_on(); clear_prog();
    prog[0] = 12'h006; prog[1] = 12'h0F9; prog[2] = 12'h800; prog[3] = 12'h2FF; prog[4] = 12'hF00;
    reset_off();
    run_until_halt(10, "t6_halt");
`ifdef MUL_EN
    chk("t6_Y", int'(Y), -42);
    chk("t6_err", int'(error), 0);
    chk("t6_fault", int'(fault), 0);
    chk("t6_pc", int'(imem_addr), 4);
`else
    chk("t6_Y", int'(Y), 0);
    chk("t6_fault", int'(fault), 1);
    chk("t6_pc", int'(imem_addr), 2);
`endif

    // Random programs against the model.
    x_rand = 1'b1;
    for (int k = 0; k < 60; k++) begin
      reset_on();
      gen_random();
      reset_off();
      n = 0;
      while (!halted && n < 150) begin cycle(); n++; end
      repeat (2) cycle();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
